// File: rtl/exmem_pkg.sv
// Shared EX->MEM types: payload bundle and writeback-select encodings.
// Payload field widths follow the default block parameters.
package exmem_pkg;

   localparam int XM_DATA_W   = 32;
   localparam int XM_ADDR_W   = 32;
   localparam int XM_RF_W     = 5;
   localparam int XM_MEMSEL_W = 3;
   localparam int XM_RAMSEL_W = 2;

   localparam logic [1:0] MEMTOREG_ALU = 2'b00;
   localparam logic [1:0] MEMTOREG_MEM = 2'b01;
   localparam logic [1:0] MEMTOREG_PC  = 2'b10;

   typedef struct packed {
      logic [XM_DATA_W-1:0]   alu_out;
      logic [XM_DATA_W-1:0]   write_data;
      logic [XM_RF_W-1:0]     write_reg;
      logic [XM_ADDR_W-1:0]   pc_plus4;
      logic                   reg_write;
      logic [1:0]             mem_to_reg;
      logic                   mem_write;
      logic [XM_MEMSEL_W-1:0] mem_data_sel;
      logic [XM_RAMSEL_W-1:0] ram_sel;
   } exmem_payload_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready pipeline slot with optional skid entry and flush.
// With SKID_EN the upstream ready comes straight from a flop.
module pipe_skid_buf #(
   parameter int W       = 8,
   parameter bit SKID_EN = 1'b1
) (
   input  logic         i_CLK,
   input  logic         i_RST,
   input  logic         i_Flush,
   input  logic         i_Valid,
   output logic         o_Ready,
   input  logic [W-1:0] i_Data,
   output logic         o_Valid,
   input  logic         i_Ready,
   output logic [W-1:0] o_Data
);

   logic         head_v;
   logic [W-1:0] head_d;
   logic         head_free;
   logic         accept;

   assign head_free = ~head_v | i_Ready;
   assign accept    = i_Valid & o_Ready;
   assign o_Valid   = head_v;
   assign o_Data    = head_d;

   generate
      if (SKID_EN) begin : g_skid
         logic         skid_v;
         logic [W-1:0] skid_d;

         assign o_Ready = ~skid_v;

         // A full skid always drains into a free head before new data.
         always_ff @(posedge i_CLK or posedge i_RST) begin
            if (i_RST) begin
               head_v <= 1'b0;
               skid_v <= 1'b0;
               head_d <= '0;
               skid_d <= '0;
            end else if (i_Flush) begin
               head_v <= 1'b0;
               skid_v <= 1'b0;
            end else if (head_free) begin
               if (skid_v) begin
                  head_v <= 1'b1;
                  head_d <= skid_d;
                  skid_v <= 1'b0;
               end else begin
                  head_v <= accept;
                  if (accept) head_d <= i_Data;
               end
            end else if (accept) begin
               skid_v <= 1'b1;
               skid_d <= i_Data;
            end
         end
      end else begin : g_single
         assign o_Ready = head_free;

         always_ff @(posedge i_CLK or posedge i_RST) begin
            if (i_RST) begin
               head_v <= 1'b0;
               head_d <= '0;
            end else if (i_Flush) begin
               head_v <= 1'b0;
            end else if (head_free) begin
               head_v <= accept;
               if (accept) head_d <= i_Data;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/exmem_elastic_reg.sv
// EX->MEM elastic pipeline register: skid slot plus write-strobe gating.
// Only the two strobes are qualified; other M fields need o_ValidM.
module exmem_elastic_reg
   import exmem_pkg::*;
#(
   parameter int DATA_WIDTH    = XM_DATA_W,
   parameter int ADDRESS_WIDTH = XM_ADDR_W,
   parameter int RF_ADDR_WIDTH = XM_RF_W,
   parameter int MEMSEL_WIDTH  = XM_MEMSEL_W,
   parameter int RAMSEL_WIDTH  = XM_RAMSEL_W,
   parameter bit SKID_EN       = 1'b1
) (
   input  logic                     i_CLK,
   input  logic                     i_RST,
   input  logic                     i_FlushM,
   input  logic                     i_ValidE,
   output logic                     o_ReadyE,
   input  logic [DATA_WIDTH-1:0]    i_ALUOutE,
   input  logic [DATA_WIDTH-1:0]    i_WriteDataE,
   input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegE,
   input  logic [ADDRESS_WIDTH-1:0] i_PCPlus4E,
   input  logic                     i_RegWriteE,
   input  logic [1:0]               i_MemtoRegE,
   input  logic                     i_MemWriteE,
   input  logic [MEMSEL_WIDTH-1:0]  i_MemDataSelE,
   input  logic [RAMSEL_WIDTH-1:0]  i_RAM_selE,
   output logic                     o_ValidM,
   input  logic                     i_ReadyM,
   output logic [DATA_WIDTH-1:0]    o_ALUOutM,
   output logic [DATA_WIDTH-1:0]    o_WriteDataM,
   output logic [RF_ADDR_WIDTH-1:0] o_WriteRegM,
   output logic [ADDRESS_WIDTH-1:0] o_PCPlus4M,
   output logic                     o_RegWriteM,
   output logic [1:0]               o_MemtoRegM,
   output logic                     o_MemWriteM,
   output logic [MEMSEL_WIDTH-1:0]  o_MemDataSelM,
   output logic [RAMSEL_WIDTH-1:0]  o_RAM_selM
);

   localparam int W = $bits(exmem_payload_t);

   exmem_payload_t pl_e;
   exmem_payload_t pl_m;

   always_comb begin
      pl_e              = '0;
      pl_e.alu_out      = i_ALUOutE;
      pl_e.write_data   = i_WriteDataE;
      pl_e.write_reg    = i_WriteRegE;
      pl_e.pc_plus4     = i_PCPlus4E;
      pl_e.reg_write    = i_RegWriteE;
      pl_e.mem_to_reg   = i_MemtoRegE;
      pl_e.mem_write    = i_MemWriteE;
      pl_e.mem_data_sel = i_MemDataSelE;
      pl_e.ram_sel      = i_RAM_selE;
   end

   pipe_skid_buf #(
      .W       (W),
      .SKID_EN (SKID_EN)
   ) u_slot (
      .i_CLK   (i_CLK),
      .i_RST   (i_RST),
      .i_Flush (i_FlushM),
      .i_Valid (i_ValidE),
      .o_Ready (o_ReadyE),
      .i_Data  (pl_e),
      .o_Valid (o_ValidM),
      .i_Ready (i_ReadyM),
      .o_Data  (pl_m)
   );

   assign o_ALUOutM     = pl_m.alu_out;
   assign o_WriteDataM  = pl_m.write_data;
   assign o_WriteRegM   = pl_m.write_reg;
   assign o_PCPlus4M    = pl_m.pc_plus4;
   assign o_MemtoRegM   = pl_m.mem_to_reg;
   assign o_MemDataSelM = pl_m.mem_data_sel;
   assign o_RAM_selM    = pl_m.ram_sel;

   // Invalid slots must never write the RF or RAM.
   assign o_RegWriteM = pl_m.reg_write & o_ValidM;
   assign o_MemWriteM = pl_m.mem_write & o_ValidM;

endmodule

// File: tb/tb_exmem_elastic_reg.sv
// Bench for exmem_elastic_reg: directed table, corner sequences,
// and random traffic against queue models for both SKID_EN builds.
module tb_exmem_elastic_reg;
   import exmem_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic flush, v_e, r_m;
   exmem_payload_t pl;

   logic rdy1, v1, rw1, mw1;
   logic rdy0, v0, rw0, mw0;
   exmem_payload_t o1, o0;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   exmem_elastic_reg #(.SKID_EN(1'b1)) dut1 (
      .i_CLK(clk), .i_RST(rst), .i_FlushM(flush),
      .i_ValidE(v_e), .o_ReadyE(rdy1),
      .i_ALUOutE(pl.alu_out), .i_WriteDataE(pl.write_data),
      .i_WriteRegE(pl.write_reg), .i_PCPlus4E(pl.pc_plus4),
      .i_RegWriteE(pl.reg_write), .i_MemtoRegE(pl.mem_to_reg),
      .i_MemWriteE(pl.mem_write), .i_MemDataSelE(pl.mem_data_sel),
      .i_RAM_selE(pl.ram_sel),
      .o_ValidM(v1), .i_ReadyM(r_m),
      .o_ALUOutM(o1.alu_out), .o_WriteDataM(o1.write_data),
      .o_WriteRegM(o1.write_reg), .o_PCPlus4M(o1.pc_plus4),
      .o_RegWriteM(rw1), .o_MemtoRegM(o1.mem_to_reg),
      .o_MemWriteM(mw1), .o_MemDataSelM(o1.mem_data_sel),
      .o_RAM_selM(o1.ram_sel)
   );

   exmem_elastic_reg #(.SKID_EN(1'b0)) dut0 (
      .i_CLK(clk), .i_RST(rst), .i_FlushM(flush),
      .i_ValidE(v_e), .o_ReadyE(rdy0),
      .i_ALUOutE(pl.alu_out), .i_WriteDataE(pl.write_data),
      .i_WriteRegE(pl.write_reg), .i_PCPlus4E(pl.pc_plus4),
      .i_RegWriteE(pl.reg_write), .i_MemtoRegE(pl.mem_to_reg),
      .i_MemWriteE(pl.mem_write), .i_MemDataSelE(pl.mem_data_sel),
      .i_RAM_selE(pl.ram_sel),
      .o_ValidM(v0), .i_ReadyM(r_m),
      .o_ALUOutM(o0.alu_out), .o_WriteDataM(o0.write_data),
      .o_WriteRegM(o0.write_reg), .o_PCPlus4M(o0.pc_plus4),
      .o_RegWriteM(rw0), .o_MemtoRegM(o0.mem_to_reg),
      .o_MemWriteM(mw0), .o_MemDataSelM(o0.mem_data_sel),
      .o_RAM_selM(o0.ram_sel)
   );

   assign o1.reg_write = rw1;
   assign o1.mem_write = mw1;
   assign o0.reg_write = rw0;
   assign o0.mem_write = mw0;

   typedef struct {
      bit          fl, ve, rm, rw, mw;
      logic [31:0] alu;
      bit          ev, erdy, erw, emw;
      logic [31:0] ealu;
   } vec_t;

   vec_t tbl[$];
   exmem_payload_t q1[$];
   exmem_payload_t q0[$];

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(bit fl, bit ve, bit rm, logic [31:0] alu,
                               bit rw, bit mw, bit ev, bit erdy,
                               logic [31:0] ealu, bit erw, bit emw);
      vec_t t;
      t.fl = fl; t.ve = ve; t.rm = rm; t.alu = alu;
      t.rw = rw; t.mw = mw; t.ev = ev; t.erdy = erdy;
      t.ealu = ealu; t.erw = erw; t.emw = emw;
      return t;
   endfunction

   task automatic chk_dut(input string tag, input logic v, input logic rdy,
                          input exmem_payload_t act, input bit ev,
                          input bit erdy, input exmem_payload_t exp);
      chk({tag, "_valid"}, 128'(v), 128'(ev));
      chk({tag, "_ready"}, 128'(rdy), 128'(erdy));
      if (ev) chk({tag, "_payload"}, 128'(act), 128'(exp));
      else chk({tag, "_strobes"}, {126'd0, act.reg_write, act.mem_write}, 128'd0);
   endtask

   initial begin
      exmem_payload_t e1, e0;
      bit b1v, b1r, b0v, b0r;
      rst = 1'b1; flush = 0; v_e = 0; r_m = 0; pl = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 128'(v1), 0);
      chk("rst_alu", 128'(o1.alu_out), 0);
      chk("rst_strobes", {126'd0, rw1, mw1}, 0);
      @(negedge clk); rst = 1'b0; #1;
      chk("rel_ready", 128'(rdy1), 1);

      tbl.push_back(mk(0,1,1,32'h1,1,0, 0,1,0,0,0));
      tbl.push_back(mk(0,1,1,32'h2,1,0, 1,1,32'h1,1,0));
      tbl.push_back(mk(0,1,1,32'h3,1,0, 1,1,32'h2,1,0));
      tbl.push_back(mk(0,1,1,32'h4,1,0, 1,1,32'h3,1,0));
      tbl.push_back(mk(0,0,1,32'h0,0,0, 1,1,32'h4,1,0));
      tbl.push_back(mk(0,1,0,32'hA,0,0, 0,1,0,0,0));
      tbl.push_back(mk(0,1,0,32'hB,0,0, 1,1,32'hA,0,0));
      tbl.push_back(mk(0,1,0,32'hE,0,0, 1,0,32'hA,0,0));
      tbl.push_back(mk(0,0,1,32'h0,0,0, 1,0,32'hA,0,0));
      tbl.push_back(mk(0,0,1,32'h0,0,0, 1,1,32'hB,0,0));
      tbl.push_back(mk(0,1,0,32'h10,1,1, 0,1,0,0,0));
      tbl.push_back(mk(0,1,0,32'h11,1,1, 1,1,32'h10,1,1));
      tbl.push_back(mk(1,1,0,32'hC,1,1, 1,0,32'h10,1,1));
      tbl.push_back(mk(1,1,1,32'hC,1,1, 0,1,0,0,0));
      tbl.push_back(mk(0,0,1,32'h0,0,0, 0,1,0,0,0));
      tbl.push_back(mk(0,1,1,32'h20,1,1, 0,1,0,0,0));
      tbl.push_back(mk(0,0,1,32'h0,0,0, 1,1,32'h20,1,1));
      tbl.push_back(mk(0,0,1,32'h0,0,0, 0,1,0,0,0));
      tbl.push_back(mk(0,0,0,32'h0,0,0, 0,1,0,0,0));

      foreach (tbl[i]) begin
         @(negedge clk);
         flush = tbl[i].fl; v_e = tbl[i].ve; r_m = tbl[i].rm;
         pl = '0;
         pl.alu_out = tbl[i].alu;
         pl.reg_write = tbl[i].rw;
         pl.mem_write = tbl[i].mw;
         #1;
         chk($sformatf("tbl%0d_valid", i), 128'(v1), 128'(tbl[i].ev));
         chk($sformatf("tbl%0d_ready", i), 128'(rdy1), 128'(tbl[i].erdy));
         chk($sformatf("tbl%0d_rw", i), 128'(rw1), 128'(tbl[i].erw));
         chk($sformatf("tbl%0d_mw", i), 128'(mw1), 128'(tbl[i].emw));
         if (tbl[i].ev)
            chk($sformatf("tbl%0d_alu", i), 128'(o1.alu_out), 128'(tbl[i].ealu));
      end

      // Reset in the middle of a stall with the skid occupied.
      @(negedge clk);
      flush = 0; v_e = 1; r_m = 0; pl = '0;
      pl.alu_out = 32'h40; pl.reg_write = 1; pl.mem_write = 1;
      @(negedge clk); pl.alu_out = 32'h41;
      @(negedge clk); v_e = 0; #1;
      chk("stall_ready", 128'(rdy1), 0);
      chk("stall_alu", 128'(o1.alu_out), 128'h40);
      #2; rst = 1'b1; #1;
      chk("arst_valid", 128'(v1), 0);
      chk("arst_alu", 128'(o1.alu_out), 0);
      chk("arst_strobes", {126'd0, rw1, mw1}, 0);
      chk("arst_valid0", 128'(v0), 0);
      @(negedge clk); rst = 1'b0; #1;
      chk("arst_rel_ready", 128'(rdy1), 1);
      chk("arst_rel_valid", 128'(v1), 0);

      // Single-entry build: combinational ready follows i_ReadyM.
      @(negedge clk);
      v_e = 1; r_m = 0; pl = '0; pl.alu_out = 32'h30; #1;
      chk("se_ready_empty", 128'(rdy0), 1);
      @(negedge clk); v_e = 0; r_m = 0; #1;
      chk("se_held_valid", 128'(v0), 1);
      chk("se_ready_held", 128'(rdy0), 0);
      r_m = 1; #1;
      chk("se_ready_follow", 128'(rdy0), 1);
      v_e = 1; pl.alu_out = 32'h31;
      @(negedge clk); v_e = 0; #1;
      chk("se_b2b_alu", 128'(o0.alu_out), 128'h31);
      chk("se_b2b_valid", 128'(v0), 1);

      @(negedge clk); flush = 1; v_e = 0;
      q1.delete(); q0.delete();

      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         flush = ($urandom_range(0, 15) == 0);
         v_e = ($urandom_range(0, 3) != 0);
         r_m = ($urandom_range(0, 2) != 0);
         pl.alu_out      = $urandom;
         pl.write_data   = $urandom;
         pl.write_reg    = 5'($urandom);
         pl.pc_plus4     = $urandom;
         pl.reg_write    = 1'($urandom);
         pl.mem_to_reg   = 2'($urandom_range(0, 2));
         pl.mem_write    = 1'($urandom);
         pl.mem_data_sel = 3'($urandom);
         pl.ram_sel      = 2'($urandom);
         #1;
         b1v = q1.size() > 0;
         b1r = q1.size() < 2;
         b0v = q0.size() > 0;
         b0r = (q0.size() == 0) || r_m;
         e1 = b1v ? q1[0] : '0;
         e0 = b0v ? q0[0] : '0;
         chk_dut("skid", v1, rdy1, o1, b1v, b1r, e1);
         chk_dut("single", v0, rdy0, o0, b0v, b0r, e0);
         if (flush) begin
            q1.delete(); q0.delete();
         end else begin
            if (b1v && r_m) void'(q1.pop_front());
            if (v_e && b1r) q1.push_back(pl);
            if (b0v && r_m) void'(q0.pop_front());
            if (v_e && b0r) q0.push_back(pl);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
